// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: word width and FSM encoding.
package ram_arbiter_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: two request/ack ports plus busy.
interface ram_arbiter_if #(
   parameter int ADDR_W = 14
);
   import ram_arbiter_pkg::*;

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [WORD_W-1:0] wdata0;
   logic [WORD_W-1:0] wdata1;
   logic              ack0;
   logic              ack1;
   logic [WORD_W-1:0] rdata0;
   logic [WORD_W-1:0] rdata1;
   logic              busy;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  ack0, ack1, rdata0, rdata1, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output ack0, ack1, rdata0, rdata1, busy
   );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port not granted last time wins.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      grant = 1'b0;
      if (req0 && req1) begin
         grant = ~last_grant;
      end else if (req1) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM, with optional zero-fill after reset.
//  state  | meaning
//  CLEAR  | writing zero to every RAM word, counter-addressed
//  IDLE   | waiting for a request; grant latches the winner's command
//  ACCESS | one cycle driving the RAM with the latched command
//  DONE   | one-cycle ack to the winner
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clock,
   input  logic              reset_n,
   ram_arbiter_if.slave      bus,
   output logic [WORD_W-1:0] ram_in,
   output logic              ram_load,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [WORD_W-1:0] ram_out
);

   localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic              last_grant;
   logic              lat_idx;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [WORD_W-1:0] lat_wdata;
   logic [WORD_W-1:0] rdata0_q;
   logic [WORD_W-1:0] rdata1_q;
   logic              grant;
   logic              grant_valid;

   rr_arb2 u_arb (
      .req0       (bus.req0),
      .req1       (bus.req1),
      .last_grant (last_grant),
      .grant      (grant),
      .valid      (grant_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= RST_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clr_cnt    <= '0;
         last_grant <= 1'b1;
         lat_idx    <= 1'b0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
         if (state == ST_IDLE && grant_valid) begin
            last_grant <= grant;
            lat_idx    <= grant;
            lat_we     <= grant ? bus.we1    : bus.we0;
            lat_addr   <= grant ? bus.addr1  : bus.addr0;
            lat_wdata  <= grant ? bus.wdata1 : bus.wdata0;
         end
         if (state == ST_ACCESS && !lat_we) begin
            if (lat_idx) begin
               rdata1_q <= ram_out;
            end else begin
               rdata0_q <= ram_out;
            end
         end
      end
   end

   // Clear writes are gated by reset_n so the RAM never sees a load while reset is held.
   always_comb begin
      state_nxt   = state;
      ram_load    = 1'b0;
      ram_address = lat_addr;
      ram_in      = lat_wdata;
      case (state)
         ST_CLEAR: begin
            ram_load    = reset_n;
            ram_in      = '0;
            ram_address = clr_cnt;
            if (clr_cnt == {ADDR_W{1'b1}}) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (grant_valid) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ram_load  = lat_we;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = RST_STATE;
         end
      endcase
   end

   always_comb begin
      bus.ack0   = (state == ST_DONE) && !lat_idx;
      bus.ack1   = (state == ST_DONE) &&  lat_idx;
      bus.rdata0 = rdata0_q;
      bus.rdata1 = rdata1_q;
      bus.busy   = (state != ST_IDLE) || bus.req0 || bus.req1;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: ADDR_W=4 scenarios plus an ADDR_W=14 smoke run.
module tb_ram_arbiter;

   typedef struct {
      int          p;
      logic        we;
      logic [3:0]  a;
      logic [15:0] d;
      logic [15:0] exp_rd;
   } vec_t;

   logic clock;
   logic reset_n;
   logic rst_big_n;
   logic preload;
   int   cyc;
   int   n_cmp;
   int   n_bad;

   ram_arbiter_if #(.ADDR_W(4))  bus ();
   ram_arbiter_if #(.ADDR_W(14)) bus_big ();

   logic [15:0] ram_in,      ram_out,      ram_in_big,      ram_out_big;
   logic        ram_load,    ram_load_big;
   logic [3:0]  ram_address;
   logic [13:0] ram_address_big;

   ram_arbiter #(.ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .bus         (bus),
      .ram_in      (ram_in),
      .ram_load    (ram_load),
      .ram_address (ram_address),
      .ram_out     (ram_out)
   );

   ram_arbiter #(.ADDR_W(14), .CLEAR_ON_RESET(1'b1)) dut_big (
      .clock       (clock),
      .reset_n     (rst_big_n),
      .bus         (bus_big),
      .ram_in      (ram_in_big),
      .ram_load    (ram_load_big),
      .ram_address (ram_address_big),
      .ram_out     (ram_out_big)
   );

   // RAM16K-style models: combinational read, write on rising edge when load is high
   logic [15:0] mem     [0:15];
   logic [15:0] mem_big [0:16383];

   assign ram_out     = mem[ram_address];
   assign ram_out_big = mem_big[ram_address_big];

   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'hFFFF;
         for (int i = 0; i < 16384; i++) mem_big[i] <= 16'hFFFF;
      end else begin
         if (ram_load)     mem[ram_address]         <= ram_in;
         if (ram_load_big) mem_big[ram_address_big] <= ram_in_big;
      end
   end

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected rdata per port, pushed at request time and popped on ack
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int          ack_log[$];
   int          load_cnt;
   int          first_load_addr;
   int          last_load_cyc;
   int          big_load_cnt;
   logic [15:0] e_rd;

   always @(negedge clock) begin
      if (bus.ack0 || bus.ack1) begin
         chk("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
         if (bus.ack0) begin
            ack_log.push_back(0);
            if (q0.size() == 0) begin
               chk("unexpected_ack0", 32'd1, 32'd0);
            end else begin
               e_rd = q0.pop_front();
               chk("rdata0", {16'd0, bus.rdata0}, {16'd0, e_rd});
            end
         end
         if (bus.ack1) begin
            ack_log.push_back(1);
            if (q1.size() == 0) begin
               chk("unexpected_ack1", 32'd1, 32'd0);
            end else begin
               e_rd = q1.pop_front();
               chk("rdata1", {16'd0, bus.rdata1}, {16'd0, e_rd});
            end
         end
      end
      if (reset_n && ram_load) begin
         if (load_cnt == 0) first_load_addr = int'(ram_address);
         load_cnt++;
         last_load_cyc = cyc;
      end
      if (rst_big_n && ram_load_big) big_load_cnt++;
   end

   task automatic port_access(input int p, input logic we, input logic [3:0] a,
                              input logic [15:0] d, input logic [15:0] exp_rd,
                              input int exp_lat, output int ack_cyc);
      int start;
      bit seen;
      @(posedge clock);
      #1;
      if (p == 0) begin
         bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
         q0.push_back(exp_rd);
      end else begin
         bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
         q1.push_back(exp_rd);
      end
      start = cyc;
      seen  = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock);
         if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) seen = 1'b1;
      end
      ack_cyc = cyc;
      chk("ack_seen", {31'd0, seen}, 32'd1);
      if (seen && exp_lat > 0) chk("ack_latency", cyc - start, exp_lat);
      @(posedge clock);
      #1;
      if (p == 0) bus.req0 = 1'b0;
      else        bus.req1 = 1'b0;
   endtask

   task automatic wait_idle(input int bound, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clock);
         if (!bus.busy) ok = 1'b1;
      end
      chk(name, {31'd0, ok}, 32'd1);
   endtask

   task automatic reset_pulse();
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_ack0",     {31'd0, bus.ack0}, 32'd0);
      chk("rst_ack1",     {31'd0, bus.ack1}, 32'd0);
      chk("rst_ram_load", {31'd0, ram_load}, 32'd0);
      chk("rst_rdata0",   {16'd0, bus.rdata0}, 32'd0);
      chk("rst_rdata1",   {16'd0, bus.rdata1}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      load_cnt = 0;
      reset_n  = 1'b1;
   endtask

   vec_t vecs[10];
   int   exp_tie[4]  = '{0, 1, 0, 1};
   int   exp_cont[7] = '{1, 0, 1, 0, 1, 0, 1};

   initial begin
      int  c;
      int  n1;
      bit  seen;
      int  start;

      vecs[0] = '{1, 1'b1, 4'd2,  16'hABCD, 16'h0000};
      vecs[1] = '{1, 1'b0, 4'd2,  16'h0000, 16'hABCD};
      vecs[2] = '{0, 1'b1, 4'd2,  16'h5555, 16'h1234};
      vecs[3] = '{1, 1'b1, 4'd7,  16'h0F0F, 16'hABCD};
      vecs[4] = '{0, 1'b0, 4'd7,  16'h0000, 16'h0F0F};
      vecs[5] = '{1, 1'b0, 4'd2,  16'h0000, 16'h5555};
      vecs[6] = '{0, 1'b0, 4'd15, 16'h0000, 16'h0000};
      vecs[7] = '{0, 1'b1, 4'd15, 16'hFFFF, 16'h0000};
      vecs[8] = '{1, 1'b0, 4'd15, 16'h0000, 16'hFFFF};
      vecs[9] = '{0, 1'b0, 4'd5,  16'h0000, 16'h1234};

      cyc = 0; n_cmp = 0; n_bad = 0; load_cnt = 0; big_load_cnt = 0;
      first_load_addr = -1; last_load_cyc = 0;
      reset_n = 1'b0; rst_big_n = 1'b0; preload = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      bus_big.req0 = 0; bus_big.req1 = 0; bus_big.we0 = 0; bus_big.we1 = 0;
      bus_big.addr0 = '0; bus_big.addr1 = '0; bus_big.wdata0 = '0; bus_big.wdata1 = '0;
      repeat (2) @(posedge clock);
      #1;
      preload   = 1'b0;
      rst_big_n = 1'b1;

      // reset / clear
      reset_pulse();
      wait_idle(40, "clear_done");
      chk("clear_loads", load_cnt, 16);
      chk("clear_first_addr", first_load_addr, 0);
      for (int i = 0; i < 16; i++) chk("clear_word", {16'd0, mem[i]}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);

      // ties: port0 wins the first tie after reset, then alternation repeats
      ack_log.delete();
      for (int r = 0; r < 2; r++) begin
         fork
            port_access(0, 1'b0, 4'd0, 16'h0, 16'h0000, 2, c);
            begin
               int c1;
               port_access(1, 1'b0, 4'd1, 16'h0, 16'h0000, 5, c1);
            end
         join
      end
      chk("tie_log_len", ack_log.size(), 4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("tie_order", ack_log[i], exp_tie[i]);

      // write then read back on port 0
      port_access(0, 1'b1, 4'd5, 16'h1234, 16'h0000, 2, c);
      chk("wr_mem5", {16'd0, mem[5]}, 32'h1234);
      port_access(0, 1'b0, 4'd5, 16'h0000, 16'h1234, 2, c);
      chk("rd_rdata0_held", {16'd0, bus.rdata0}, 32'h1234);

      for (int i = 0; i < 10; i++)
         port_access(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 2, c);

      // contention: port1 holds req, port0 issues three reads back to back
      ack_log.delete();
      fork
         begin
            n1 = 0;
            @(posedge clock);
            #1;
            bus.we1 = 1'b0; bus.addr1 = 4'd2; bus.req1 = 1'b1;
            repeat (4) q1.push_back(16'h5555);
            for (int i = 0; i < 200 && n1 < 4; i++) begin
               @(negedge clock);
               if (bus.ack1) n1++;
            end
            chk("cont_p1_acks", n1, 4);
            @(posedge clock);
            #1;
            bus.req1 = 1'b0;
         end
         begin
            for (int k = 0; k < 3; k++) port_access(0, 1'b0, 4'd2, 16'h0, 16'h5555, 0, c);
         end
      join
      chk("cont_log_len", ack_log.size(), 7);
      for (int i = 0; i < 7 && i < ack_log.size(); i++) chk("cont_order", ack_log[i], exp_cont[i]);

      // request raised during clear is served two cycles after entering IDLE
      reset_pulse();
      repeat (3) @(posedge clock);
      port_access(1, 1'b0, 4'd2, 16'h0, 16'h0000, 0, c);
      chk("clear_req_ack_cyc", c, last_load_cyc + 3);
      chk("clear_req_loads", load_cnt, 16);

      // reset in the middle of a write access
      port_access(0, 1'b1, 4'd3, 16'h3333, 16'h0000, 2, c);
      chk("pre_mem3", {16'd0, mem[3]}, 32'h3333);
      @(posedge clock);
      #1;
      bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 16'hAAAA; bus.req0 = 1'b1;
      @(posedge clock);
      #2;
      chk("access_load", {31'd0, ram_load}, 32'd1);
      chk("access_addr", {28'd0, ram_address}, 32'd3);
      chk("access_busy", {31'd0, bus.busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_ack0", {31'd0, bus.ack0}, 32'd0);
      chk("abort_load", {31'd0, ram_load}, 32'd0);
      bus.req0 = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      load_cnt = 0;
      first_load_addr = -1;
      reset_n = 1'b1;
      wait_idle(40, "abort_clear_done");
      chk("abort_loads", load_cnt, 16);
      chk("abort_first_addr", first_load_addr, 0);
      chk("abort_mem3", {16'd0, mem[3]}, 32'd0);
      chk("abort_q0_empty", q0.size(), 0);

      // ADDR_W=14 smoke: full clear, then one write/read
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clock);
         if (!bus_big.busy) seen = 1'b1;
      end
      chk("big_clear_done", {31'd0, seen}, 32'd1);
      chk("big_loads", big_load_cnt, 16384);
      chk("big_mem_first", {16'd0, mem_big[0]}, 32'd0);
      chk("big_mem_last",  {16'd0, mem_big[16383]}, 32'd0);
      for (int op = 0; op < 2; op++) begin
         @(posedge clock);
         #1;
         bus_big.we0 = (op == 0); bus_big.addr0 = 14'h3ABC; bus_big.wdata0 = 16'hC0DE;
         bus_big.req0 = 1'b1;
         start = cyc;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (bus_big.ack0) seen = 1'b1;
         end
         chk("big_ack_seen", {31'd0, seen}, 32'd1);
         chk("big_latency", cyc - start, 2);
         @(posedge clock);
         #1;
         bus_big.req0 = 1'b0;
      end
      chk("big_mem", {16'd0, mem_big[14'h3ABC]}, 32'hC0DE);
      chk("big_rdata0", {16'd0, bus_big.rdata0}, 32'hC0DE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: RAM address width (RAM16K).
REQ-002 Parameter CLEAR_ON_RESET, default 1: zero-fill the RAM after reset release.
REQ-003 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Ports: req0/req1  in  1 each  access request, held high until the matching ack.
REQ-006 Ports: we0/we1  in  1 each  1 = write, 0 = read.
REQ-007 Ports: addr0/addr1  in  ADDR_W each  word address.
REQ-008 Ports: wdata0/wdata1  in  16 each  write data.
REQ-009 Ports: ack0/ack1  out  1 each  one-cycle completion pulse.
REQ-010 Ports: rdata0/rdata1  out  16 each  read result, registered.
REQ-011 Port: busy  out  1  high during CLEAR or any transaction.
REQ-012 Ports: ram_in  out  16, ram_load  out  1, ram_address  out  ADDR_W  drive the RAM's in, load and address pins.
REQ-013 Port: ram_out  in  16  RAM output; combinational from ram_address.

Function
REQ-014 FSM states: CLEAR, IDLE, ACCESS, DONE.
REQ-015 CLEAR: ram_load=1, ram_in=0, ram_address=clear counter; the counter increments every cycle from 0; after address 2**ADDR_W-1 is written, go to IDLE.
REQ-016 Requests arriving during CLEAR are held off; no ack is issued until IDLE.
REQ-017 IDLE: ram_load=0; if any req is high, latch the winner's index, we, addr and wdata, then go to ACCESS; otherwise stay.
REQ-018 Arbitration is round-robin:
- single request wins;
- if both are high, the port not granted last wins;
- last_grant updates on every grant.
REQ-019 ACCESS (exactly one cycle):
- ram_address = latched addr;
- ram_in = latched wdata;
- ram_load = latched we;
- on read, ram_out is captured into the winner's rdata register at the closing edge;
- then go to DONE.
REQ-020 DONE: the winner's ack is high for exactly one cycle; ram_load=0; next state IDLE.
REQ-021 Latency: req sampled in IDLE at edge N; ack high in cycle N+2; rdata valid from cycle N+2 and held until that port's next read completes.
REQ-022 Writes also ack; the writer's rdata is unchanged.
REQ-023 Requester must drop req in the cycle after ack; req still high in IDLE is a new request.
REQ-024 The latched request is immune to changes on req/addr/we/wdata after the grant edge.
REQ-025 ack0 and ack1 are never high together; the non-granted port's request waits at most one transaction.
REQ-026 busy = (state != IDLE) or any req high.
REQ-027 Outside CLEAR and ACCESS: ram_load=0, ram_address = latched addr, ram_in = latched wdata.

Reset
REQ-028 On reset_n low, immediately and regardless of state:
- state = CLEAR if CLEAR_ON_RESET, else IDLE;
- clear counter = 0;
- last_grant = 1, so port 0 wins the first tie;
- ack0 = ack1 = 0;
- rdata0 = rdata1 = 0;
- ram_load = 0;
- latched fields = 0.
REQ-029 Reset mid-ACCESS or mid-CLEAR aborts the operation; no ack is issued; a fresh CLEAR restarts from address 0.

Structure
REQ-030 Shared package holds the state encoding (CLEAR=0, IDLE=1, ACCESS=2, DONE=3) and the word width constant 16.
REQ-031 One sub-module: rr_arb2 (2-way round-robin picker: req0, req1, last_grant -> grant index, valid).
REQ-032 The RAM16K instance lives outside this block; the bench connects it.

Verification
REQ-033 Bench runs with ADDR_W=4 for CLEAR speed, plus one ADDR_W=14 smoke run.
REQ-034 Scenario (reset/clear): preload RAM with 16'hFFFF, pulse reset_n, wait for busy to fall -> all 16 words read 0; exactly 16 ram_load cycles.
REQ-035 Scenario (write/read): port0 writes 16'h1234 to addr 5, then reads addr 5 -> ack0 at req edge+2 both times; rdata0=16'h1234.
REQ-036 Scenario (tie): req0 and req1 rise together -> order ack0 then ack1, then on the next tie ack0 then ack1 again; never both high together.
REQ-037 Scenario (contention): port1 held high continuously, port0 issues 3 back-to-back reads -> grants alternate; port1 never waits more than one transaction.
REQ-038 Scenario (mid-access reset): assert reset_n low during ACCESS of a write to addr 3 -> no ack, CLEAR restarts at 0, addr 3 ends at 0.
REQ-039 Scenario (request during clear): raise req1 during CLEAR -> ack1 only after the last clear write, 2 cycles after entering IDLE.
